// File: rtl/prf_mp.sv
// Physical register file with NUM_WB writeback ports, per-register ready bits,
// and a round-robin arbitrated, registered read broadcast slot with valid/ready.
module prf_mp #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned PRF_SIZE = 16,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WB   = 2,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned ID_W    = $clog2(PRF_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*ID_W-1:0]   wb_id,
  input  logic [NUM_WB*DATA_W-1:0] wb_val,
  input  logic [NUM_WB-1:0]        wb_mark_rdy,
  input  logic [NUM_RD-1:0]        rd_req,
  input  logic [NUM_RD*ID_W-1:0]   rd_id,
  output logic [NUM_RD-1:0]        rd_grant,
  input  logic                     retire_ena,
  input  logic [ID_W-1:0]          retire_id,
  output logic [PRF_SIZE-1:0]      ready_regs,
  output logic                     cdb_valid,
  output logic [ID_W-1:0]          cdb_id,
  output logic [DATA_W-1:0]        cdb_val,
  input  logic                     cdb_ready
);

  localparam int unsigned RR_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

  logic [DATA_W-1:0]   rf_q [PRF_SIZE];
  logic [DATA_W-1:0]   rf_d [PRF_SIZE];
  logic [PRF_SIZE-1:0] rdy_q, rdy_d;
  logic                cdb_valid_q, cdb_valid_d;
  logic [ID_W-1:0]     cdb_id_q, cdb_id_d;
  logic [DATA_W-1:0]   cdb_val_q, cdb_val_d;
  logic [RR_W-1:0]     rr_q, rr_d;

  logic                slot_free;
  logic                gnt_any;
  logic [RR_W-1:0]     gnt_idx;
  logic [RR_W-1:0]     cand;
  logic [NUM_RD-1:0]   grant;
  logic [ID_W-1:0]     sel_id;
  logic [DATA_W-1:0]   sel_val;
  logic [ID_W-1:0]     wid;
  logic [PRF_SIZE-1:0] wr_hit, wr_mark;

  // Round-robin search starting at rr_q; no grant while the slot is occupied or in reset.
  always_comb begin
    grant     = '0;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    slot_free = !cdb_valid_q || cdb_ready;
    if (slot_free && !rst) begin
      for (int unsigned i = 0; i < NUM_RD; i++) begin
        cand = RR_W'((32'(rr_q) + i) % NUM_RD);
        if (!gnt_any && rd_req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_id  = rd_id[32'(gnt_idx)*ID_W +: ID_W];
    sel_val = rf_q[sel_id];
    if (BYPASS != 0) begin
      for (int unsigned k = 0; k < NUM_WB; k++) begin
        if (wb_valid[k] && (wb_id[k*ID_W +: ID_W] == sel_id) && (sel_id != '0))
          sel_val = wb_val[k*DATA_W +: DATA_W];
      end
    end
  end

  // Ascending port order lets the highest index win both data and mark on id conflicts.
  always_comb begin
    rf_d    = rf_q;
    wr_hit  = '0;
    wr_mark = '0;
    wid     = '0;
    for (int unsigned k = 0; k < NUM_WB; k++) begin
      wid = wb_id[k*ID_W +: ID_W];
      if (wb_valid[k] && (wid != '0)) begin
        rf_d[wid]    = wb_val[k*DATA_W +: DATA_W];
        wr_hit[wid]  = 1'b1;
        wr_mark[wid] = wb_mark_rdy[k];
      end
    end
    rdy_d = rdy_q;
    if (retire_ena) rdy_d[retire_id] = 1'b0;
    rdy_d    = rdy_d | (wr_hit & wr_mark);
    rdy_d[0] = 1'b1;
  end

  always_comb begin
    cdb_valid_d = cdb_valid_q;
    cdb_id_d    = cdb_id_q;
    cdb_val_d   = cdb_val_q;
    rr_d        = rr_q;
    if (gnt_any) begin
      cdb_valid_d = 1'b1;
      cdb_id_d    = sel_id;
      cdb_val_d   = sel_val;
      rr_d        = RR_W'((32'(gnt_idx) + 1) % NUM_RD);
    end else if (cdb_ready) begin
      cdb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < PRF_SIZE; i++) rf_q[i] <= '0;
      rdy_q       <= PRF_SIZE'(1);
      cdb_valid_q <= 1'b0;
      cdb_id_q    <= '0;
      cdb_val_q   <= '0;
      rr_q        <= '0;
    end else begin
      rf_q        <= rf_d;
      rdy_q       <= rdy_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_id_q    <= cdb_id_d;
      cdb_val_q   <= cdb_val_d;
      rr_q        <= rr_d;
    end
  end

  assign rd_grant   = grant;
  assign ready_regs = rdy_q;
  assign cdb_valid  = cdb_valid_q;
  assign cdb_id     = cdb_id_q;
  assign cdb_val    = cdb_val_q;

endmodule
